alu_reg4: RTL and testbench
===========================

Name: alu_reg4

Overview:
- Small registered arithmetic/logic unit operating on two WIDTH-bit operands, selected by a 4-bit opcode.
- Computes the operation combinationally, then registers result, carry_flag and zero_flag on the rising clock edge.
- Serves as the datapath execution unit of the simple processor datapath.
- One operation is accepted every cycle; there is no handshake.

Parameters:
- WIDTH, 4, operand/result width in bits. All opcode behaviour below is defined for the default of 4; the opcode width is fixed at 4.

Ports:
- clk  input  1  system clock; rising-edge active.
- rst  input  1  synchronous, active-high reset.
- A  input  WIDTH  operand A, unsigned.
- B  input  WIDTH  operand B, unsigned.
- opcode  input  4  operation select.
- result  output  WIDTH  registered operation result.
- carry_flag  output  1  registered carry, borrow, overflow or error flag.
- zero_flag  output  1  registered; 1 when the registered result is 0.

Behaviour:
- Single clock domain (clk); reset is synchronous and active-high (rst).
- rst sampled high at a rising edge sets result=0, carry_flag=0 and zero_flag=1. rst has priority over any operation presented in that cycle.
- Latency: inputs sampled at edge N appear on the outputs after edge N. Outputs then hold until the next edge.
- Throughput: one operation per cycle. Back-to-back opcodes are fully independent; no state is carried between operations.
- zero_flag = (next result == 0), computed for every opcode, including undefined ones.
- Opcode map (all arithmetic unsigned; "carry" means the value registered into carry_flag):
  - 0000 ADD: {carry,result} = A+B. carry = bit WIDTH of the sum (7+8 -> 15, carry 0; 15+1 -> 0, carry 1).
  - 0001 SUB: result = (A-B) mod 2^WIDTH. carry = borrow = (A<B) (5-5 -> 0, carry 0, zero 1; 3-5 -> 14, carry 1).
  - 0010 AND: result = A&B; carry=0.
  - 0011 OR: result = A|B; carry=0.
  - 0100 NOT: result = ~A (B ignored); carry=0.
  - 0101 MUL: full product P = A*B (2*WIDTH bits). result = P[WIDTH-1:0]. carry = overflow = (P > 2^WIDTH-1) (3*4 -> 12, carry 0; 8*4=32 -> 0, carry 1).
  - 0110 DIV: result = A/B, truncated quotient; carry=0. If B==0, result=0 and carry=1 (divide-by-zero error); zero_flag follows result, so it is 1.
  - 0111 XOR: result = A^B; carry=0.
  - 1001 SHL: result = A<<1; carry = A[WIDTH-1].
  - 1010 SHR: result = A>>1 (logical); carry = A[0].
  - 1111 PASS: result = A; carry=0.
  - Undefined opcodes (1000, 1011-1110): result=0, carry=0, zero_flag=1. No X propagation.
- Boundary cases:
  - MUL with either operand 0: result 0, carry 0, zero 1.
  - DIV with A<B: result 0, carry 0, zero 1.
  - DIV 15/1: result 15.
  - ADD/SUB wrap modulo 2^WIDTH.
- Inputs are not registered separately. Outputs never change except at a clk rising edge.
- Reset mid-stream: the operation presented in the reset cycle is discarded. The first post-reset operation appears one cycle after rst deasserts.

Test Plan:
- Assert rst for 2 cycles with A=9, B=3, opcode=1111 -> result=0, carry=0, zero=1. Release rst -> next edge result=9, carry=0, zero=0.
- Arithmetic, one per cycle:
  - ADD 7+8 -> 15/c0/z0
  - ADD 15+1 -> 0/c1/z1
  - SUB 5-5 -> 0/c0/z1
  - SUB 3-5 -> 14/c1/z0
- Logic:
  - AND A=0xA, B=0xC -> 8
  - OR -> 14
  - XOR -> 6
  - NOT A=0xC -> 3
  - PASS A=9 -> 9
  - All with carry=0.
- MUL/DIV:
  - MUL 3*4 -> 12/c0
  - MUL 8*4 -> 0/c1/z1
  - DIV 9/3 -> 3/c0
  - DIV 5/0 -> 0/c1/z1
  - DIV 2/5 -> 0/c0/z1
- Shifts and undefined:
  - SHL A=0x9 -> 2/c1
  - SHR A=0x9 -> 4/c1
  - Opcode 1000 with A=B=3 -> 0/c0/z1
  - Opcodes 1011-1110 -> 0/c0/z1
- Latency check: change the opcode every cycle with no idle cycles. Each output must match the operation sampled on the preceding edge exactly; no cross-cycle leakage.

Source files
------------

// File: rtl/alu_reg4.sv
// alu_reg4: registered arithmetic/logic unit for the simple processor datapath.
//
// The operation selected by opcode is evaluated combinationally from A and B.
// result, carry_flag and zero_flag are then captured on the rising edge of clk.
// A new operation is accepted every cycle. Nothing is carried from one
// operation to the next, and there is no handshake.
//
// Ports:
//   clk        in   1      system clock, rising-edge active
//   rst        in   1      synchronous active-high reset (result=0, carry=0, zero=1)
//   A          in   WIDTH  operand A, unsigned
//   B          in   WIDTH  operand B, unsigned
//   opcode     in   4      operation select
//   result     out  WIDTH  registered result
//   carry_flag out  1      registered carry / borrow / overflow / divide-error flag
//   zero_flag  out  1      registered, 1 when the registered result is zero
//
// Opcode map:
//   0000 ADD   0001 SUB   0010 AND   0011 OR    0100 NOT   0101 MUL
//   0110 DIV   0111 XOR   1001 SHL   1010 SHR   1111 PASS
//   others: result 0, carry 0

module alu_reg4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       opcode,
    output logic [WIDTH-1:0] result,
    output logic             carry_flag,
    output logic             zero_flag
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_NOT  = 4'b0100;
    localparam logic [3:0] OP_MUL  = 4'b0101;
    localparam logic [3:0] OP_DIV  = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0111;
    localparam logic [3:0] OP_SHL  = 4'b1001;
    localparam logic [3:0] OP_SHR  = 4'b1010;
    localparam logic [3:0] OP_PASS = 4'b1111;

    logic [WIDTH-1:0]   result_d, result_q;
    logic               carry_d, carry_q;
    logic               zero_d, zero_q;

    // Widened intermediates. The bits above WIDTH give the carry and the
    // overflow without any extra compare logic.
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;

    always_comb begin
        sum  = {1'b0, A} + {1'b0, B};
        // The extra top bit becomes 1 exactly when A < B, which is the borrow.
        diff = {1'b0, A} - {1'b0, B};
        prod = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
        // Guarded so that divide-by-zero never produces an X quotient.
        quot = (B != '0) ? (A / B) : '0;
    end

    always_comb begin
        result_d = '0;
        carry_d  = 1'b0;
        unique case (opcode)
            OP_ADD: begin
                result_d = sum[WIDTH-1:0];
                carry_d  = sum[WIDTH];
            end
            OP_SUB: begin
                result_d = diff[WIDTH-1:0];
                carry_d  = diff[WIDTH];
            end
            OP_AND:  result_d = A & B;
            OP_OR:   result_d = A | B;
            OP_NOT:  result_d = ~A;
            OP_MUL: begin
                result_d = prod[WIDTH-1:0];
                // Any set bit in the upper half means the product does not fit.
                carry_d  = |prod[2*WIDTH-1:WIDTH];
            end
            OP_DIV: begin
                result_d = quot;
                carry_d  = (B == '0);
            end
            OP_XOR:  result_d = A ^ B;
            OP_SHL: begin
                result_d = {A[WIDTH-2:0], 1'b0};
                carry_d  = A[WIDTH-1];
            end
            OP_SHR: begin
                result_d = {1'b0, A[WIDTH-1:1]};
                carry_d  = A[0];
            end
            OP_PASS: result_d = A;
            default: begin
                result_d = '0;
                carry_d  = 1'b0;
            end
        endcase
        // The zero flag is derived from the value about to be registered, so it
        // always agrees with result, including for undefined opcodes.
        zero_d = (result_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b1;
        end else begin
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
        end
    end

    assign result     = result_q;
    assign carry_flag = carry_q;
    assign zero_flag  = zero_q;

endmodule

// File: tb/tb_alu_reg4.sv
// Bench for alu_reg4. Directed vectors carry hand-computed expectations.
// A monitor also checks every cycle against an arithmetic model of the opcode
// map.
module tb_alu_reg4;

    localparam int WIDTH = 4;
    localparam int MAXV  = 2 ** WIDTH;

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] A = 4'd9;
    logic [WIDTH-1:0] B = 4'd3;
    logic [3:0]       opcode = 4'b1111;
    logic [WIDTH-1:0] result;
    logic             carry_flag;
    logic             zero_flag;

    always #5 clk = ~clk;

    alu_reg4 #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .A          (A),
        .B          (B),
        .opcode     (opcode),
        .result     (result),
        .carry_flag (carry_flag),
        .zero_flag  (zero_flag)
    );

    int n_vec = 0;
    int n_err = 0;

    // ---------------- behavioural model ----------------
    // The model works on plain integers. It returns {zero, carry, result}.
    function automatic logic [WIDTH+1:0] model(input logic r, input logic [3:0] op,
                                               input int a, input int b);
        int res;
        int c;
        res = 0;
        c   = 0;
        if (!r) begin
            case (op)
                4'd0:  begin res = (a + b) % MAXV; c = (a + b >= MAXV) ? 1 : 0; end
                4'd1:  begin res = (a - b + MAXV) % MAXV; c = (a < b) ? 1 : 0; end
                4'd2:  res = a & b;
                4'd3:  res = a | b;
                4'd4:  res = (MAXV - 1) - a;
                4'd5:  begin res = (a * b) % MAXV; c = (a * b >= MAXV) ? 1 : 0; end
                4'd6:  begin
                    if (b == 0) begin res = 0; c = 1; end
                    else res = a / b;
                end
                4'd7:  res = a ^ b;
                4'd9:  begin res = (a * 2) % MAXV; c = (a >= MAXV / 2) ? 1 : 0; end
                4'd10: begin res = a / 2; c = a % 2; end
                4'd15: res = a;
                default: begin res = 0; c = 0; end
            endcase
        end
        model = {(res == 0) ? 1'b1 : 1'b0, c[0], res[WIDTH-1:0]};
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [WIDTH-1:0] ar, input logic ac,
                         input logic az, input logic [WIDTH-1:0] er, input logic ec,
                         input logic ez);
        n_vec++;
        if (ar !== er || ac !== ec || az !== ez) begin
            n_err++;
            $display("FAIL %s: got result=%0d carry=%b zero=%b, want result=%0d carry=%b zero=%b",
                     name, ar, ac, az, er, ec, ez);
        end
    endtask

    // The monitor captures the inputs at each rising edge. It compares the
    // registered outputs 1 time unit later.
    logic [WIDTH+1:0] mon_exp;
    always begin
        @(posedge clk);
        mon_exp = model(rst, opcode, int'(A), int'(B));
        #1;
        check("model", result, carry_flag, zero_flag,
              mon_exp[WIDTH-1:0], mon_exp[WIDTH], mon_exp[WIDTH+1]);
    end

    // ---------------- driver tasks ----------------
    // Inputs change on the falling edge. Each call uses exactly one cycle, so
    // successive calls run back to back with no idle cycles.
    task automatic drive(input logic r, input logic [3:0] op, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b);
        @(negedge clk);
        rst = r; opcode = op; A = a; B = b;
    endtask

    task automatic apply(input string name, input logic r, input logic [3:0] op,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] er, input logic ec, input logic ez);
        logic [WIDTH+1:0] m;
        drive(r, op, a, b);
        // Pin the model itself against the hand-computed value.
        m = model(r, op, int'(a), int'(b));
        check({name, "/model"}, m[WIDTH-1:0], m[WIDTH], m[WIDTH+1], er, ec, ez);
        @(posedge clk);
        #1;
        check(name, result, carry_flag, zero_flag, er, ec, ez);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset for 2 cycles while a PASS operation is presented.
        apply("rst1", 1'b1, 4'b1111, 4'd9, 4'd3, 4'd0, 1'b0, 1'b1);
        apply("rst2", 1'b1, 4'b1111, 4'd9, 4'd3, 4'd0, 1'b0, 1'b1);
        apply("pass_after_rst", 1'b0, 4'b1111, 4'd9, 4'd3, 4'd9, 1'b0, 1'b0);

        apply("add_7_8",   1'b0, 4'b0000, 4'd7,  4'd8, 4'd15, 1'b0, 1'b0);
        apply("add_15_1",  1'b0, 4'b0000, 4'd15, 4'd1, 4'd0,  1'b1, 1'b1);
        apply("sub_5_5",   1'b0, 4'b0001, 4'd5,  4'd5, 4'd0,  1'b0, 1'b1);
        apply("sub_3_5",   1'b0, 4'b0001, 4'd3,  4'd5, 4'd14, 1'b1, 1'b0);

        apply("and",       1'b0, 4'b0010, 4'hA, 4'hC, 4'd8,  1'b0, 1'b0);
        apply("or",        1'b0, 4'b0011, 4'hA, 4'hC, 4'd14, 1'b0, 1'b0);
        apply("xor",       1'b0, 4'b0111, 4'hA, 4'hC, 4'd6,  1'b0, 1'b0);
        apply("not",       1'b0, 4'b0100, 4'hC, 4'h5, 4'd3,  1'b0, 1'b0);
        apply("pass",      1'b0, 4'b1111, 4'd9, 4'hF, 4'd9,  1'b0, 1'b0);

        apply("mul_3_4",   1'b0, 4'b0101, 4'd3, 4'd4, 4'd12, 1'b0, 1'b0);
        apply("mul_8_4",   1'b0, 4'b0101, 4'd8, 4'd4, 4'd0,  1'b1, 1'b1);
        apply("mul_0_9",   1'b0, 4'b0101, 4'd0, 4'd9, 4'd0,  1'b0, 1'b1);
        apply("mul_5_3",   1'b0, 4'b0101, 4'd5, 4'd3, 4'd15, 1'b0, 1'b0);
        apply("div_9_3",   1'b0, 4'b0110, 4'd9, 4'd3, 4'd3,  1'b0, 1'b0);
        apply("div_5_0",   1'b0, 4'b0110, 4'd5, 4'd0, 4'd0,  1'b1, 1'b1);
        apply("div_2_5",   1'b0, 4'b0110, 4'd2, 4'd5, 4'd0,  1'b0, 1'b1);
        apply("div_15_1",  1'b0, 4'b0110, 4'd15, 4'd1, 4'd15, 1'b0, 1'b0);

        apply("shl_9",     1'b0, 4'b1001, 4'h9, 4'h0, 4'd2,  1'b1, 1'b0);
        apply("shr_9",     1'b0, 4'b1010, 4'h9, 4'h0, 4'd4,  1'b1, 1'b0);
        apply("shl_6",     1'b0, 4'b1001, 4'h6, 4'h0, 4'd12, 1'b0, 1'b0);
        apply("shr_6",     1'b0, 4'b1010, 4'h6, 4'h0, 4'd3,  1'b0, 1'b0);
        apply("undef_8",   1'b0, 4'b1000, 4'd3, 4'd3, 4'd0,  1'b0, 1'b1);
        for (int op = 11; op <= 14; op++) begin
            apply($sformatf("undef_%0d", op), 1'b0, op[3:0], 4'd7, 4'd5, 4'd0, 1'b0, 1'b1);
        end

        // Reset in the middle of a stream. The operation presented with rst is
        // discarded, and the next operation appears one cycle later.
        apply("add_pre",   1'b0, 4'b0000, 4'd2, 4'd3, 4'd5, 1'b0, 1'b0);
        apply("mid_rst",   1'b1, 4'b0000, 4'd7, 4'd8, 4'd0, 1'b0, 1'b1);
        apply("post_rst",  1'b0, 4'b0001, 4'd3, 4'd5, 4'd14, 1'b1, 1'b0);

        // Back-to-back sweep. Opcode and operands change every cycle, and the
        // monitor checks each result against the model.
        for (int i = 0; i < 64; i++) begin
            drive(1'b0, 4'(i % 16), 4'((i * 7 + 3) % 16), 4'((i * 5) % 16));
        end
        drive(1'b0, 4'b1111, 4'd0, 4'd0);
        @(posedge clk);
        #2;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #20000;
        $display("FAIL watchdog: got timeout, want completion");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "timeout");
    end

endmodule
